sram_rr_arbiter: RTL and testbench

// - Shares the single asynchronous SRAM port (cs/we/oe/address/data) between two requesters.
// - Round-robin grant; one access in flight at a time.
// - Sequences each SRAM read or write with programmable wait states and a turnaround cycle.
// - Sits between the pmram model/device and the requester FSMs, in place of a single direct-driving FSM.

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_rr_pick.sv | 14 +
 rtl/sram_rr_arbiter.sv | 119 +++++++++++
 tb/tb_sram_rr_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared constants for the two-requester SRAM arbiter: FSM state codes,
// default bus widths and SRAM control polarities.
package sram_pkg;

  localparam int SRAM_AW = 8;
  localparam int SRAM_DW = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_WR    = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_TURN  = 3'd5;

  localparam logic CS_ON = 1'b1;
  localparam logic WE_ON = 1'b1;
  localparam logic OE_ON = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin picker: with both requesting, the one not served last
// wins; a lone requester always wins.
module sram_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant_oh
);

  always_comb begin
    grant_oh = req;
    if (req == 2'b11) grant_oh = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM port between two
// requesters; sequences SETUP / wait-stated access / DONE hold / TURN release.
module sram_rr_arbiter
  import sram_pkg::*;
#(
  parameter int AW      = SRAM_AW,
  parameter int DW      = SRAM_DW,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata1,
  output logic          cs,
  output logic          we,
  output logic          oe,
  output logic [AW-1:0] address,
  inout  wire  [DW-1:0] data
);

  localparam int CW = $clog2(max_int(RD_WAIT, WR_WAIT) + 1);

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          own, wr_q, last, drv;
  logic [DW-1:0] wdata_q;
  logic [1:0]    gnt_oh;
  logic          take, sel, own_nxt, wr_nxt, active;

  sram_rr_pick u_pick (
    .req      ({req1, req0}),
    .last     (last),
    .grant_oh (gnt_oh)
  );

  assign take = (state == ST_IDLE) && (gnt_oh != 2'b00);
  assign sel  = gnt_oh[1];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (take) state_nxt = ST_SETUP;
      ST_SETUP:     state_nxt = wr_q ? ST_WR : ST_RD;
      ST_RD, ST_WR: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_TURN;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Bus controls are registered from the next state so they change cleanly on the edge.
  assign own_nxt = take ? sel : own;
  assign wr_nxt  = take ? (sel ? wr1 : wr0) : wr_q;
  assign active  = (state_nxt == ST_SETUP) || (state_nxt == ST_RD) ||
                   (state_nxt == ST_WR)    || (state_nxt == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      own     <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      address <= '0;
      last    <= 1'b1;
      drv     <= 1'b0;
      cs      <= ~CS_ON;
      we      <= ~WE_ON;
      oe      <= ~OE_ON;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        own     <= sel;
        wr_q    <= sel ? wr1 : wr0;
        address <= sel ? addr1 : addr0;
        wdata_q <= sel ? wdata1 : wdata0;
      end
      // Reload on entry, count down to zero and hold there.
      if (state == ST_SETUP)
        cnt <= wr_q ? CW'(WR_WAIT - 1) : CW'(RD_WAIT - 1);
      else if (((state == ST_RD) || (state == ST_WR)) && (cnt != '0))
        cnt <= cnt - 1'b1;
      if ((state == ST_RD) && (cnt == '0)) begin
        if (own) rdata1 <= data;
        else     rdata0 <= data;
      end
      if (state == ST_DONE) last <= own;
      cs    <= active ? CS_ON : ~CS_ON;
      we    <= (state_nxt == ST_WR) ? WE_ON : ~WE_ON;
      oe    <= (state_nxt == ST_RD) ? OE_ON : ~OE_ON;
      drv   <= active && wr_nxt;
      gnt0  <= active && !own_nxt;
      gnt1  <= active && own_nxt;
      done0 <= (state_nxt == ST_DONE) && !own_nxt;
      done1 <= (state_nxt == ST_DONE) && own_nxt;
    end
  end

  assign data = drv ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Randomised scoreboard bench for sram_rr_arbiter with a behavioural SRAM and
// a second instance using RD_WAIT=1 / WR_WAIT=3.
module tb_sram_rr_arbiter;
  localparam int AW = 8, DW = 4, RD_WAIT = 2, WR_WAIT = 2;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } op_t;

  logic clk, reset, clr;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;

  logic [1:0]    req, wr, gnt, done;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] rdata [2];
  logic          cs_a, we_a, oe_a;
  logic [AW-1:0] address_a;
  wire  [DW-1:0] data_a;

  logic          b_req, b_wr, b_gnt, b_done, b_gnt1, b_done1;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata, b_rdata1;
  logic          cs_b, we_b, oe_b;
  logic [AW-1:0] address_b;
  wire  [DW-1:0] data_b;

  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] ref_mem [256];
  op_t q0[$], q1[$];
  int  gnt_log[$];
  int  done_cnt [2];
  int  cs_n, we_n, oe_n;
  logic [1:0] prev_gnt;

  sram_rr_arbiter #(.AW(AW), .DW(DW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .wr0(wr[0]), .addr0(addr[0]), .wdata0(wdata[0]),
    .gnt0(gnt[0]), .done0(done[0]), .rdata0(rdata[0]),
    .req1(req[1]), .wr1(wr[1]), .addr1(addr[1]), .wdata1(wdata[1]),
    .gnt1(gnt[1]), .done1(done[1]), .rdata1(rdata[1]),
    .cs(cs_a), .we(we_a), .oe(oe_a), .address(address_a), .data(data_a)
  );

  sram_rr_arbiter #(.AW(AW), .DW(DW), .RD_WAIT(1), .WR_WAIT(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .req0(b_req), .wr0(b_wr), .addr0(b_addr), .wdata0(b_wdata),
    .gnt0(b_gnt), .done0(b_done), .rdata0(b_rdata),
    .req1(1'b0), .wr1(1'b0), .addr1('0), .wdata1('0),
    .gnt1(b_gnt1), .done1(b_done1), .rdata1(b_rdata1),
    .cs(cs_b), .we(we_b), .oe(oe_b), .address(address_b), .data(data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural asynchronous SRAMs
  assign data_a = (cs_a && oe_a && !we_a) ? mem_a[address_a] : 'z;
  assign data_b = (cs_b && oe_b && !we_b) ? mem_b[address_b] : 'z;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) begin mem_a[i] <= '0; mem_b[i] <= '0; end
    end else begin
      if (cs_a && we_a) mem_a[address_a] <= data_a;
      if (cs_b && we_b) mem_b[address_b] <= data_b;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: bus-level checks and scoreboard pop on each done pulse
  always @(negedge clk) begin : mon
    op_t e;
    bit  have;
    int  r;
    if (!reset) begin
      cs_n = 0; we_n = 0; oe_n = 0; prev_gnt = '0;
    end else begin
      chk("we_oe_excl", {31'b0, we_a & oe_a}, 0);
      chk("gnt_excl", {31'b0, gnt[0] & gnt[1]}, 0);
      r    = gnt[1] ? 1 : 0;
      have = r ? (q1.size() != 0) : (q0.size() != 0);
      if (have) e = r ? q1[0] : q0[0];
      if (cs_a) begin
        cs_n++;
        if (we_a) we_n++;
        if (oe_a) oe_n++;
        if (have) begin
          chk("address", address_a, e.addr);
          if (we_a) chk("wr_data", data_a, e.wdata);
        end
      end
      for (int i = 0; i < 2; i++)
        if (gnt[i] && !prev_gnt[i]) gnt_log.push_back(i);
      prev_gnt = gnt;
      for (int i = 0; i < 2; i++) if (done[i]) begin
        if (!(have && r == i)) begin
          n_chk++;
          $display("FAIL done%0d: unexpected pulse, gnt=%b queued=%0d", i, gnt, have);
        end else begin
          if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          done_cnt[i]++;
          if (e.wr) begin
            chk("cs_len_wr", cs_n, WR_WAIT + 2);
            chk("we_len", we_n, WR_WAIT);
            chk("oe_during_wr", oe_n, 0);
            chk("wr_data_hold", data_a, e.wdata);
          end else begin
            chk("cs_len_rd", cs_n, RD_WAIT + 2);
            chk("oe_len", oe_n, RD_WAIT);
            chk("we_during_rd", we_n, 0);
            chk("rdata", rdata[i], e.rdata);
          end
        end
        cs_n = 0; we_n = 0; oe_n = 0;
      end
    end
  end

  task automatic issue(input int r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit keep, input bit timed);
    op_t e;
    int  t0;
    bit  got;
    @(posedge clk); #1;
    e.wr = w; e.addr = a; e.wdata = d; e.rdata = ref_mem[a];
    if (w) ref_mem[a] = d;
    if (r == 0) q0.push_back(e); else q1.push_back(e);
    req[r] = 1'b1; wr[r] = w; addr[r] = a; wdata[r] = d; t0 = cyc;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done[r]) begin got = 1; break; end
    end
    chk($sformatf("done%0d_seen", r), {31'b0, got}, 1);
    if (got && timed) chk("latency", cyc - t0 + 1, 3 + (w ? WR_WAIT : RD_WAIT));
    @(posedge clk); #1;
    if (!keep) req[r] = 1'b0;
  endtask

  task automatic b_access(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp);
    int t0, wen, oen;
    bit got;
    got = 0; wen = 0; oen = 0;
    @(posedge clk); #1;
    b_req = 1'b1; b_wr = w; b_addr = a; b_wdata = d; t0 = cyc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (we_b) wen++;
      if (oe_b) oen++;
      if (b_done) begin got = 1; break; end
    end
    chk("b_done_seen", {31'b0, got}, 1);
    if (got) begin
      chk("b_latency", cyc - t0 + 1, w ? 6 : 4);
      if (w) begin
        chk("b_we_len", wen, 3);
        chk("b_data_hold", data_b, d);
      end else begin
        chk("b_oe_len", oen, 1);
        chk("b_rdata", b_rdata, exp);
      end
    end
    @(posedge clk); #1;
    b_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  base;
    bit  got;
    reset = 1'b0; clr = 1'b1; req = '0; wr = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_cs", {31'b0, cs_a}, 0);
    chk("rst_we_oe", {30'b0, we_a, oe_a}, 0);
    chk("rst_gnt_done", {28'b0, gnt, done}, 0);
    chk("rst_address", address_a, 0);
    chk("rst_rdata", {rdata[1], rdata[0]}, 0);
    clr = 1'b0; reset = 1'b1;

    // Single write, then read-back by the other requester
    issue(0, 1'b1, 8'h3C, 4'hA, 0, 1);
    issue(1, 1'b0, 8'h3C, 4'h0, 0, 1);

    // Same-cycle contention, both held across two accesses each
    base = gnt_log.size();
    fork
      begin issue(0, 1'b1, 8'h10, 4'h5, 1, 0); issue(0, 1'b0, 8'h10, 4'h0, 0, 0); end
      begin issue(1, 1'b0, 8'h90, 4'h0, 1, 0); issue(1, 1'b1, 8'h91, 4'h7, 0, 0); end
    join
    chk("contend_n", gnt_log.size() - base, 4);
    if (gnt_log.size() >= base + 4)
      for (int i = 0; i < 4; i++) chk($sformatf("contend_gnt%0d", i), gnt_log[base+i], i % 2);

    // Requester 0 hogging; requester 1 must get in within one access
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, i[0], 8'h11, 4'(i + 3), i != 3, 0);
      end
      begin : starve
        int b0;
        repeat (4) @(posedge clk);
        b0 = done_cnt[0];
        issue(1, 1'b1, 8'h92, 4'hC, 0, 0);
        chk("starve", {31'b0, (done_cnt[0] - b0) <= 1}, 1);
      end
    join

    // Reset during WR: bus releases at once, pointer restarts at requester 0
    @(posedge clk); #1;
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h20; wdata[0] = ref_mem[8'h20];
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (we_a) begin got = 1; break; end
    end
    chk("rst_reach_wr", {31'b0, got}, 1);
    reset = 1'b0; #1;
    chk("rst_mid_ctl", {29'b0, cs_a, we_a, oe_a}, 0);
    chk("rst_mid_gnt_done", {28'b0, gnt, done}, 0);
    req[0] = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    base = gnt_log.size();
    fork
      issue(0, 1'b0, 8'h3C, 4'h0, 0, 1);
      issue(1, 1'b0, 8'h90, 4'h0, 0, 0);
    join
    chk("rst_first_gnt_n", {31'b0, gnt_log.size() > base}, 1);
    if (gnt_log.size() > base) chk("rst_first_gnt", gnt_log[base], 0);

    // Random traffic, address spaces split so each stream is self-consistent
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
              DW'($urandom_range(0, 15)), 0, 0);
      end
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(1, 1'($urandom_range(0, 1)), AW'($urandom_range(128, 135)),
              DW'($urandom_range(0, 15)), 0, 0);
      end
    join
    chk("q_drained", q0.size() + q1.size(), 0);

    // Alternate wait-state configuration
    b_access(1'b1, 8'h55, 4'h6, 4'h0);
    b_access(1'b0, 8'h55, 4'h0, 4'h6);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
